// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: redirect, instruction-SRAM and decode-side signals of the fetch queue
interface ifetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ex;
    logic [5:0]  out_ecode;
    modport master (
        input  redirect_valid, redirect_pc, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, out_ready,
        output inst_sram_req, inst_sram_addr, out_valid, out_pc, out_inst, out_ex, out_ecode
    );
    modport slave (
        output redirect_valid, redirect_pc, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, out_ready,
        input  inst_sram_req, inst_sram_addr, out_valid, out_pc, out_inst, out_ex, out_ecode
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order fetch queue with redirect discard accounting; IFQ_ADEF_CHECK_EN turns misaligned pcs into exception entries
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
    input logic            clk,
    input logic            rstn,
    ifetch_queue_if.master bus
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
    logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;
    logic             live_q, live_d, stop_q, stop_d;
    logic [31:0]      ent_pc_q [DEPTH];
    logic [31:0]      ent_pc_d [DEPTH];
    logic [31:0]      ent_inst_q [DEPTH];
    logic [31:0]      ent_inst_d [DEPTH];
    logic [DEPTH-1:0] ent_fill_q, ent_fill_d, ent_ex_q, ent_ex_d;
    logic [CNT_W-1:0] occ, outst;
    logic [IW-1:0]    ai, fi, hi;
    logic             adef, can_alloc, req, rsp, pop;
    assign ai = alloc_q[IW-1:0];
    assign fi = fill_q[IW-1:0];
    assign hi = head_q[IW-1:0];
`ifdef IFQ_ADEF_CHECK_EN
    assign adef = pc_q[1:0] != 2'b00;
`else
    assign adef = 1'b0;
`endif
    // The unanswered-request count includes pending discards, which keeps it within DEPTH.
    always_comb begin
        occ       = alloc_q - head_q;
        outst     = alloc_q - fill_q - CNT_W'(stop_q);
        can_alloc = live_q && !bus.redirect_valid && !stop_q && (occ + discard_cnt_q < DEPTH_C);
        req       = can_alloc && !adef;
        rsp       = bus.inst_sram_data_ok && (discard_cnt_q != '0 || outst != '0);
        pop       = bus.out_valid && bus.out_ready && !bus.redirect_valid;
        bus.inst_sram_req  = rstn && req;
        bus.inst_sram_addr = pc_q;
        bus.out_valid      = rstn && ent_fill_q[hi];
        bus.out_pc         = ent_pc_q[hi];
        bus.out_inst       = ent_inst_q[hi];
        bus.out_ex         = bus.out_valid && ent_ex_q[hi];
        bus.out_ecode      = bus.out_ex ? 6'h08 : 6'h00;
    end
    always_comb begin
        pc_d          = pc_q;
        alloc_d       = alloc_q;
        fill_d        = fill_q;
        head_d        = head_q;
        discard_cnt_d = discard_cnt_q;
        live_d        = 1'b1;
        stop_d        = stop_q;
        ent_pc_d      = ent_pc_q;
        ent_inst_d    = ent_inst_q;
        ent_fill_d    = ent_fill_q;
        ent_ex_d      = ent_ex_q;
        if ((req && bus.inst_sram_addr_ok) || (can_alloc && adef)) begin
            ent_pc_d[ai]   = pc_q;
            ent_inst_d[ai] = '0;
            ent_ex_d[ai]   = adef;
            ent_fill_d[ai] = adef;
            alloc_d        = alloc_q + 1'b1;
            pc_d           = adef ? pc_q : pc_q + 32'd4;
            stop_d         = adef;
        end
        if (rsp && discard_cnt_q != '0) begin
            discard_cnt_d = discard_cnt_q - 1'b1;
        end else if (rsp) begin
            ent_inst_d[fi] = bus.inst_sram_rdata;
            ent_fill_d[fi] = 1'b1;
            fill_d         = fill_q + 1'b1;
        end
        if (pop) begin
            ent_fill_d[hi] = 1'b0;
            head_d         = head_q + 1'b1;
        end
        // A response in the redirect cycle is counted as discarded rather than written.
        if (bus.redirect_valid) begin
            pc_d          = bus.redirect_pc;
            alloc_d       = '0;
            fill_d        = '0;
            head_d        = '0;
            ent_fill_d    = '0;
            stop_d        = 1'b0;
            discard_cnt_d = discard_cnt_q + outst - CNT_W'(rsp);
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q          <= RESET_PC;
            alloc_q       <= '0;
            fill_q        <= '0;
            head_q        <= '0;
            discard_cnt_q <= '0;
            live_q        <= 1'b0;
            stop_q        <= 1'b0;
            ent_fill_q    <= '0;
            ent_ex_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            alloc_q       <= alloc_d;
            fill_q        <= fill_d;
            head_q        <= head_d;
            discard_cnt_q <= discard_cnt_d;
            live_q        <= live_d;
            stop_q        <= stop_d;
            ent_fill_q    <= ent_fill_d;
            ent_ex_q      <= ent_ex_d;
        end
    end
    always_ff @(posedge clk) begin
        ent_pc_q   <= ent_pc_d;
        ent_inst_q <= ent_inst_d;
    end
endmodule
